// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between requesters A and B.
// Latency: accept at edge N, ALU evaluates during N+1, response valid from N+2.
// Backpressure: one operation in flight; no request accepted until the owner takes its response.
module alu_arbiter #(
  parameter int DW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  // requester A
  input  logic          a_req_valid_i,
  output logic          a_req_ready_o,
  input  logic [DW-1:0] a_op1_i,
  input  logic [DW-1:0] a_op2_i,
  input  logic [3:0]    a_opcode_i,
  output logic          a_rsp_valid_o,
  input  logic          a_rsp_ready_i,
  // requester B
  input  logic          b_req_valid_i,
  output logic          b_req_ready_o,
  input  logic [DW-1:0] b_op1_i,
  input  logic [DW-1:0] b_op2_i,
  input  logic [3:0]    b_opcode_i,
  output logic          b_rsp_valid_o,
  input  logic          b_rsp_ready_i,
  // shared response payload, qualified by the per-port rsp_valid
  output logic [DW-1:0] rsp_res_o,
  output logic [1:0]    rsp_psr_o,
  output logic          rsp_err_o,
  // shared ALU
  output logic [DW-1:0] alu_op1_o,
  output logic [DW-1:0] alu_op2_o,
  output logic [3:0]    alu_opcode_o,
  input  logic [DW-1:0] alu_res_i,
  input  logic [1:0]    alu_psr_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Highest legal opcode (SLT); anything above is rejected with an error.
  localparam logic [3:0] OPC_LAST = 4'd5;
  localparam logic [3:0] OPC_SAFE = 4'd0;

  // Owner / pointer encoding: 0 = port A, 1 = port B.
  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          ill_q, ill_d;
  logic [DW-1:0] alu_op1_q, alu_op1_d;
  logic [DW-1:0] alu_op2_q, alu_op2_d;
  logic [3:0]    alu_opc_q, alu_opc_d;
  logic [DW-1:0] rsp_res_q, rsp_res_d;
  logic [1:0]    rsp_psr_q, rsp_psr_d;
  logic          rsp_err_q, rsp_err_d;

  logic          in_idle;
  logic          grant_b;
  logic          accept;
  logic [DW-1:0] sel_op1;
  logic [DW-1:0] sel_op2;
  logic [3:0]    sel_opc;
  logic          sel_illegal;
  logic          owner_rsp_ready;

  // Grant: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    in_idle       = (state_q == ST_IDLE);
    grant_b       = b_req_valid_i & (~a_req_valid_i | ptr_q);
    a_req_ready_o = in_idle & a_req_valid_i & ~grant_b;
    b_req_ready_o = in_idle & b_req_valid_i & grant_b;
    accept        = a_req_ready_o | b_req_ready_o;
  end

  // Operand mux for the granted port, plus illegal-opcode detection.
  always_comb begin
    sel_op1     = grant_b ? b_op1_i    : a_op1_i;
    sel_op2     = grant_b ? b_op2_i    : a_op2_i;
    sel_opc     = grant_b ? b_opcode_i : a_opcode_i;
    sel_illegal = (sel_opc > OPC_LAST);
  end

  // Only the owner's response-ready can complete the response.
  always_comb begin
    owner_rsp_ready = owner_q ? b_rsp_ready_i : a_rsp_ready_i;
  end

  // Sequencer: IDLE -> EXEC (one cycle) -> RESP (until owner takes it) -> IDLE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    ill_d     = ill_q;
    alu_op1_d = alu_op1_q;
    alu_op2_d = alu_op2_q;
    alu_opc_d = alu_opc_q;
    rsp_res_d = rsp_res_q;
    rsp_psr_d = rsp_psr_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d   = grant_b;
          ill_d     = sel_illegal;
          alu_op1_d = sel_op1;
          alu_op2_d = sel_op2;
          // Never present an undecoded opcode to the ALU.
          alu_opc_d = sel_illegal ? OPC_SAFE : sel_opc;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // An illegal opcode returns a clean zero result regardless of the ALU.
        rsp_res_d = ill_q ? '0    : alu_res_i;
        rsp_psr_d = ill_q ? 2'b00 : alu_psr_i;
        rsp_err_d = ill_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          rsp_err_d = 1'b0;
          // Round-robin hands priority to the other port; fixed mode keeps A on top.
          ptr_d     = RR ? ~owner_q : 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      ill_q     <= 1'b0;
      alu_op1_q <= '0;
      alu_op2_q <= '0;
      alu_opc_q <= 4'd0;
      rsp_res_q <= '0;
      rsp_psr_q <= 2'b00;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      ill_q     <= ill_d;
      alu_op1_q <= alu_op1_d;
      alu_op2_q <= alu_op2_d;
      alu_opc_q <= alu_opc_d;
      rsp_res_q <= rsp_res_d;
      rsp_psr_q <= rsp_psr_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Outputs come straight from registers so the ALU and requesters see glitch-free values.
  always_comb begin
    alu_op1_o     = alu_op1_q;
    alu_op2_o     = alu_op2_q;
    alu_opcode_o  = alu_opc_q;
    rsp_res_o     = rsp_res_q;
    rsp_psr_o     = rsp_psr_q;
    rsp_err_o     = rsp_err_q;
    a_rsp_valid_o = (state_q == ST_RESP) & ~owner_q;
    b_rsp_valid_o = (state_q == ST_RESP) & owner_q;
  end

endmodule
